// File: rtl/ffstdp_update.sv
// FF-STDP per-synapse weight update: derivative from post count and polarity, scaled by the
// pre count, then a signed saturating add onto the current weight, registered once.
module ffstdp_update #(
    parameter int unsigned PRE_CNT_WIDTH  = 8,
    parameter int unsigned POST_CNT_WIDTH = 7,
    parameter int unsigned WEIGHT_WIDTH   = 8,
    parameter int unsigned GOOD_THR       = 8,
    parameter int unsigned D_SHIFT        = 2,
    parameter int unsigned LR_SHIFT       = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ctrl_tref_event_i,
    input  logic                           is_pos_i,
    input  logic                           is_train_i,
    input  logic [POST_CNT_WIDTH-1:0]      post_spike_cnt_i,
    input  logic [PRE_CNT_WIDTH-1:0]       pre_spike_cnt_i,
    input  logic signed [WEIGHT_WIDTH-1:0] wsyn_curr_i,
    output logic signed [WEIGHT_WIDTH-1:0] wsyn_new_o,
    output logic                           wsyn_ovf_o,
    output logic                           wsyn_valid_o
);

    // Raw derivative holds the threshold difference or the count, shifted, before saturation.
    localparam int unsigned RawW  = POST_CNT_WIDTH + 1 + D_SHIFT;
    localparam int unsigned ProdW = PRE_CNT_WIDTH + WEIGHT_WIDTH;
    localparam int unsigned SumW  = WEIGHT_WIDTH + 1;

    localparam logic [RawW-1:0]  DRawMax   = RawW'((64'd1 << WEIGHT_WIDTH) - 64'd1);
    localparam logic [ProdW-1:0] DeltaMax  = ProdW'((64'd1 << (WEIGHT_WIDTH - 1)) - 64'd1);
    localparam logic [RawW-1:0]  ThrExt    = RawW'(GOOD_THR);

    logic [RawW-1:0]         post_ext;
    logic [RawW-1:0]         d_raw;
    logic [WEIGHT_WIDTH-1:0] d;
    logic [ProdW-1:0]        l_w;
    logic [ProdW-1:0]        mag;
    logic [WEIGHT_WIDTH-1:0] delta;
    logic [SumW-1:0]         delta_s;
    logic [SumW-1:0]         sum;
    logic [WEIGHT_WIDTH-1:0] result;
    logic                    ovf;
    logic                    apply;

    logic [WEIGHT_WIDTH-1:0] wsyn_new_d, wsyn_new_q;
    logic                    wsyn_ovf_d, wsyn_ovf_q;
    logic                    wsyn_valid_d, wsyn_valid_q;

    always_comb begin
        post_ext = RawW'(post_spike_cnt_i);
        d_raw    = '0;
        if (is_pos_i) begin
            if (post_ext < ThrExt) begin
                d_raw = (ThrExt - post_ext) << D_SHIFT;
            end
        end else begin
            d_raw = post_ext << D_SHIFT;
        end
        d = (d_raw > DRawMax) ? '1 : WEIGHT_WIDTH'(d_raw);
    end

    always_comb begin
        l_w   = ProdW'(pre_spike_cnt_i) * ProdW'(d);
        mag   = l_w >> LR_SHIFT;
        delta = (mag > DeltaMax) ? WEIGHT_WIDTH'(DeltaMax) : WEIGHT_WIDTH'(mag);
    end

    // Sum is one bit wider than the weight, so the two top bits disagree exactly on overflow.
    always_comb begin
        delta_s = is_pos_i ? {1'b0, delta} : (~{1'b0, delta} + SumW'(1));
        sum     = {wsyn_curr_i[WEIGHT_WIDTH-1], wsyn_curr_i} + delta_s;
        ovf     = sum[SumW-1] ^ sum[SumW-2];
        result  = sum[WEIGHT_WIDTH-1:0];
        if (ovf) begin
            result = sum[SumW-1] ? {1'b1, {(WEIGHT_WIDTH-1){1'b0}}}
                                 : {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};
        end
    end

    always_comb begin
        apply        = ctrl_tref_event_i & is_train_i;
        wsyn_new_d   = wsyn_curr_i;
        wsyn_ovf_d   = 1'b0;
        wsyn_valid_d = 1'b0;
        if (apply) begin
            wsyn_new_d   = result;
            wsyn_ovf_d   = ovf;
            wsyn_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wsyn_new_q   <= '0;
            wsyn_ovf_q   <= 1'b0;
            wsyn_valid_q <= 1'b0;
        end else begin
            wsyn_new_q   <= wsyn_new_d;
            wsyn_ovf_q   <= wsyn_ovf_d;
            wsyn_valid_q <= wsyn_valid_d;
        end
    end

    assign wsyn_new_o   = wsyn_new_q;
    assign wsyn_ovf_o   = wsyn_ovf_q;
    assign wsyn_valid_o = wsyn_valid_q;

endmodule

// File: tb/tb_ffstdp_update.sv
// Scoreboard bench for ffstdp_update: directed corner cases, an exhaustive small-count sweep
// and a random phase, all checked against an integer reference model.
module tb_ffstdp_update;

    logic       clk;
    logic       rst_n;
    logic       ctrl_tref_event_i;
    logic       is_pos_i;
    logic       is_train_i;
    logic [6:0] post_spike_cnt_i;
    logic [7:0] pre_spike_cnt_i;
    logic signed [7:0] wsyn_curr_i;
    logic signed [7:0] wsyn_new_o;
    logic       wsyn_ovf_o;
    logic       wsyn_valid_o;

    typedef struct {
        int    w;
        int    ovf;
        int    valid;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_errors;

    ffstdp_update dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ctrl_tref_event_i (ctrl_tref_event_i),
        .is_pos_i          (is_pos_i),
        .is_train_i        (is_train_i),
        .post_spike_cnt_i  (post_spike_cnt_i),
        .pre_spike_cnt_i   (pre_spike_cnt_i),
        .wsyn_curr_i       (wsyn_curr_i),
        .wsyn_new_o        (wsyn_new_o),
        .wsyn_ovf_o        (wsyn_ovf_o),
        .wsyn_valid_o      (wsyn_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int tref, input int train, input int pos,
                                   input int post, input int pre, input int w,
                                   input string tag);
        exp_t e;
        int d, lw, delta, s;
        e.tag = tag;
        if (!(tref != 0 && train != 0)) begin
            e.w = w; e.ovf = 0; e.valid = 0;
            return e;
        end
        if (pos != 0) d = (post < 8) ? (8 - post) * 4 : 0;
        else          d = post * 4;
        if (d > 255) d = 255;
        lw    = pre * d;
        delta = lw / 16;
        if (delta > 127) delta = 127;
        s = (pos != 0) ? w + delta : w - delta;
        e.valid = 1;
        e.ovf   = 0;
        if (s > 127)       begin e.w = 127;  e.ovf = 1; end
        else if (s < -128) begin e.w = -128; e.ovf = 1; end
        else               e.w = s;
        return e;
    endfunction

    task automatic drive(input int tref, input int train, input int pos, input int post,
                         input int pre, input int w, input string tag);
        exp_t e;
        @(negedge clk);
        ctrl_tref_event_i = (tref != 0);
        is_train_i        = (train != 0);
        is_pos_i          = (pos != 0);
        post_spike_cnt_i  = 7'(post);
        pre_spike_cnt_i   = 8'(pre);
        wsyn_curr_i       = 8'(w);
        sb.push_back(model(tref, train, pos, post, pre, w, tag));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_val({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check_val({e.tag, "_w"}, int'(wsyn_new_o), e.w);
            check_val({e.tag, "_ovf"}, int'(wsyn_ovf_o), e.ovf);
            check_val({e.tag, "_valid"}, int'(wsyn_valid_o), e.valid);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n             = 1'b0;
        ctrl_tref_event_i = 1'b1;
        is_train_i        = 1'b1;
        is_pos_i          = 1'b1;
        post_spike_cnt_i  = 7'd2;
        pre_spike_cnt_i   = 8'd10;
        wsyn_curr_i       = 8'sd55;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_w", int'(wsyn_new_o), 0);
        check_val("reset_ovf", int'(wsyn_ovf_o), 0);
        check_val("reset_valid", int'(wsyn_valid_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        drive(1, 1, 1, 2, 10, 50, "pos_update");
        drive(1, 1, 1, 8, 200, -30, "pos_at_thr");
        drive(1, 1, 0, 6, 15, -120, "neg_sat");
        drive(1, 1, 1, 0, 255, 100, "delta_cap_pos_sat");
        drive(1, 1, 0, 127, 1, 0, "neg_d_sat");
        drive(1, 1, 0, 127, 255, -128, "neg_rail");
        drive(1, 1, 1, 0, 0, 127, "pre_zero");
        drive(0, 1, 1, 0, 255, -77, "no_tref");
        drive(1, 0, 0, 100, 255, -77, "no_train");

        // Asynchronous reset in the middle of a cycle with a valid update on the outputs.
        drive(1, 1, 1, 3, 20, 10, "pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midreset_w", int'(wsyn_new_o), 0);
        check_val("midreset_ovf", int'(wsyn_ovf_o), 0);
        check_val("midreset_valid", int'(wsyn_valid_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 0, 1, 4, -5, "post_reset");

        for (int pol = 0; pol < 2; pol++) begin
            for (int pre = 0; pre < 16; pre++) begin
                for (int post = 0; post < 16; post++) begin
                    drive(1, 1, pol, post, pre, int'($urandom_range(0, 255)) - 128, "sweep");
                end
            end
        end

        for (int i = 0; i < 300; i++) begin
            drive(int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 127)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)) - 128, "rand");
        end

        check_val("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ffstdp_update.md
Name: ffstdp_update

Overview:
- Per-synapse weight-update datapath for forward-forward STDP (FF-STDP) learning in the SNN core.
- At a reference-time (tref) event during training, it derives a loss-to-spike derivative from the post-neuron spike count and the sample polarity (positive or negative).
- It scales that derivative by the pre-neuron spike count and applies the signed, saturated delta to the current weight.
- It sits between the synapse memory read port and the write-back port of the learning controller.

Parameters:
- PRE_CNT_WIDTH, 8, width of the pre-synaptic spike counter.
- POST_CNT_WIDTH, 7, width of the post-synaptic spike counter.
- WEIGHT_WIDTH, 8, signed two's-complement weight width.
- GOOD_THR, 8, goodness threshold on the post spike count.
- D_SHIFT, 2, left shift applied to the derivative magnitude.
- LR_SHIFT, 4, right shift (learning rate) applied to the pre×derivative product.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- CTRL_TREF_EVENT  input  1  update strobe from the controller (tref event).
- IS_POS  input  1  1 = positive sample, 0 = negative sample.
- IS_TRAIN  input  1  training enable.
- POST_SPIKE_CNT  input  POST_CNT_WIDTH  post-neuron spike count (unsigned).
- PRE_SPIKE_CNT  input  PRE_CNT_WIDTH  pre-neuron spike count (unsigned).
- WSYN_CURR  input  WEIGHT_WIDTH (signed)  current synaptic weight.
- WSYN_NEW  output  WEIGHT_WIDTH (signed)  registered new weight.
- WSYN_OVF  output  1  registered flag: the last computed update saturated.
- WSYN_VALID  output  1  registered flag: WSYN_NEW holds an applied update.

Behaviour:
- Reset: asynchronous, active-low. While RST_N=0: WSYN_NEW=0, WSYN_OVF=0, WSYN_VALID=0.
- Combinational pipeline, then one register stage. Latency is 1 cycle: inputs sampled at rising edge k appear on the outputs after edge k.
- Derivative d (unsigned, WEIGHT_WIDTH bits):
  - IS_POS=1: if POST<GOOD_THR, d=(GOOD_THR−POST)<<D_SHIFT; else d=0.
  - IS_POS=0: d=POST<<D_SHIFT.
  - Saturate d to 2^WEIGHT_WIDTH−1 (255).
- Product: L_w = PRE×d, unsigned, PRE_CNT_WIDTH+WEIGHT_WIDTH bits, no loss.
- Magnitude: delta = L_w>>LR_SHIFT, saturated to 2^(WEIGHT_WIDTH−1)−1 (127).
- Sign: delta_s = +delta if IS_POS, else −delta. Positive samples potentiate; negative samples depress.
- Sum: sum = WSYN_CURR + delta_s, computed at WEIGHT_WIDTH+1 bits.
  - If sum > 127, result = 127 and ovf=1.
  - If sum < −128, result = −128 and ovf=1.
  - Otherwise result = sum and ovf=0.
- Register update every cycle:
  - If CTRL_TREF_EVENT && IS_TRAIN: WSYN_NEW←result, WSYN_OVF←ovf, WSYN_VALID←1.
  - Otherwise: WSYN_NEW←WSYN_CURR (pass-through), WSYN_OVF←0, WSYN_VALID←0.
- PRE=0 or d=0 gives delta=0, so the weight is unchanged; with the strobe and IS_TRAIN high, VALID=1 and OVF=0.
- Saturation applies symmetrically at both weight rails. Weights never wrap.
- No internal state other than the output registers. Reset asserted mid-operation clears the outputs immediately; the first post-reset edge resumes normal operation.
- Inputs may change every cycle; each cycle is independent.

Test Plan:
- Reset: RST_N=0 with arbitrary inputs -> WSYN_NEW=0, OVF=0, VALID=0 asynchronously; release, then the next edge follows the rules above.
- Positive update: IS_TRAIN=1, TREF=1, IS_POS=1, POST=2, PRE=10, W=50 -> d=24, L_w=240, delta=15, WSYN_NEW=65, OVF=0, VALID=1 one cycle later.
- Positive at threshold: IS_POS=1, POST=8, PRE=200, W=−30 -> d=0, WSYN_NEW=−30, OVF=0, VALID=1.
- Negative saturation: IS_POS=0, POST=6, PRE=15, W=−120 -> d=24, L_w=360, delta=22, sum=−142 -> WSYN_NEW=−128, OVF=1.
- Delta cap and positive saturation: IS_POS=1, POST=0, PRE=255, W=100 -> d=32, L_w=8160, delta capped at 127, WSYN_NEW=127, OVF=1. Also IS_POS=0, POST=127 -> d saturates to 255.
- Disabled: IS_TRAIN=0 (or TREF=0), W=−77, any counts -> WSYN_NEW=−77, OVF=0, VALID=0. Then sweep PRE,POST=0..15 × both polarities × random W against a reference model.
